// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter for the shared 4->1 ALU operand path.
// Grants are registered, capped at HOLD_MAX cycles, and every release is followed by an idle cycle.
module alu_rr_arbiter #(
   parameter int HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       o_dbg_state,
   output logic [1:0] o_dbg_ptr
);

   localparam int CW = $clog2(HOLD_MAX + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t        r_state;
   logic [1:0]    r_ptr;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_gnt;
   logic [1:0]    r_sel;
   logic          r_busy;

   logic [1:0]    w_winner;
   logic [1:0]    w_idx;
   logic          w_found;
   logic          w_release;

   // First requester at or after ptr wins; ptr itself has the highest priority.
   always_comb begin
      w_winner = r_ptr;
      w_idx    = r_ptr;
      w_found  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_ptr + 2'(k);
         if (!w_found && req[w_idx]) begin
            w_winner = w_idx;
            w_found  = 1'b1;
         end
      end
   end

   assign w_release = !req[r_sel] || (r_cnt == CW'(HOLD_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= 2'd0;
         r_cnt   <= '0;
         r_gnt   <= 4'b0000;
         r_sel   <= 2'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_GRANT;
                  r_gnt   <= 4'b0001 << w_winner;
                  r_sel   <= w_winner;
                  r_busy  <= 1'b1;
                  r_cnt   <= CW'(1);
               end
            end
            S_GRANT: begin
               // Release always passes through IDLE, so no back-to-back grant.
               if (w_release) begin
                  r_state <= S_IDLE;
                  r_gnt   <= 4'b0000;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_sel + 2'd1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= 4'b0000;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign sel         = r_sel;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;
   assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: HOLD_MAX=4 instance for the main scenarios,
// HOLD_MAX=1 instance for single-cycle alternation.
module tb_alu_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       dbg_state;
   logic [1:0] dbg_ptr;

   logic       rst1_n;
   logic [3:0] req1;
   logic [3:0] gnt1;
   logic [1:0] sel1;
   logic       busy1;
   logic       dbg_state1;
   logic [1:0] dbg_ptr1;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected {gnt, sel, busy} after each driven edge.
   logic [6:0] exp_q[$];

   alu_rr_arbiter #(.HOLD_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel), .busy(busy),
      .o_dbg_state(dbg_state), .o_dbg_ptr(dbg_ptr)
   );

   alu_rr_arbiter #(.HOLD_MAX(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .req(req1), .gnt(gnt1), .sel(sel1), .busy(busy1),
      .o_dbg_state(dbg_state1), .o_dbg_ptr(dbg_ptr1)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Checker
   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Driver: apply req to the chosen instance, push expectation, clock one edge, pop and compare.
   task automatic cyc(input string tag, input bit which, input logic [3:0] r,
                      input logic [3:0] eg, input logic [1:0] es);
      logic [6:0] e;
      logic [6:0] o;
      if (which) req1 = r;
      else       req  = r;
      exp_q.push_back({eg, es, |eg});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = which ? {gnt1, sel1, busy1} : {gnt, sel, busy};
      check(tag, o, e);
   endtask

   task automatic check_ptr(input string tag, input logic [1:0] ep);
      check(tag, {5'd0, dbg_ptr}, {5'd0, ep});
   endtask

   // Every-cycle invariant on both instances: gnt zero or one-hot, busy == |gnt.
   always @(negedge clk) begin
      check("inv_onehot", {6'd0, $onehot0(gnt)}, 7'd1);
      check("inv_busy", {6'd0, busy}, {6'd0, |gnt});
      check("inv1_onehot", {6'd0, $onehot0(gnt1)}, 7'd1);
      check("inv1_busy", {6'd0, busy1}, {6'd0, |gnt1});
   end

   initial begin
      rst_n  = 1'b0;
      rst1_n = 1'b0;
      req    = 4'b0000;
      req1   = 4'b0000;
      #12;
      check("reset_outputs", {gnt, sel, busy}, 7'd0);
      check_ptr("reset_ptr", 2'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      rst1_n = 1'b1;

      // Idle with no requests
      cyc("idle_noreq", 0, 4'b0000, 4'b0000, 2'd0);

      // All requesting: 0,1,2,3,0 each for 4 cycles with one idle gap
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 4; j++)
            cyc("rr_all_grant", 0, 4'b1111, 4'b0001 << (k % 4), 2'(k % 4));
         cyc("rr_all_gap", 0, 4'b1111, 4'b0000, 2'(k % 4));
      end
      check_ptr("rr_all_ptr", 2'd1);
      cyc("rr_all_stop", 0, 4'b0000, 4'b0000, 2'd0);

      // Requester 2 for two cycles then drops
      cyc("r2_grant", 0, 4'b0100, 4'b0100, 2'd2);
      cyc("r2_hold", 0, 4'b0100, 4'b0100, 2'd2);
      cyc("r2_release", 0, 4'b0000, 4'b0000, 2'd2);
      check_ptr("r2_ptr", 2'd3);
      cyc("r2_idle", 0, 4'b0000, 4'b0000, 2'd2);

      // Wrap-around from ptr=3
      cyc("wrap_g3", 0, 4'b1001, 4'b1000, 2'd3);
      cyc("wrap_rel3", 0, 4'b0001, 4'b0000, 2'd3);
      check_ptr("wrap_ptr", 2'd0);
      cyc("wrap_g0", 0, 4'b0001, 4'b0001, 2'd0);
      cyc("wrap_rel0", 0, 4'b0000, 4'b0000, 2'd0);
      check_ptr("wrap_ptr2", 2'd1);

      // Other requesters arriving during a grant are ignored
      cyc("ign_g1", 0, 4'b0010, 4'b0010, 2'd1);
      cyc("ign_hold1", 0, 4'b1011, 4'b0010, 2'd1);
      cyc("ign_hold2", 0, 4'b1011, 4'b0010, 2'd1);
      cyc("ign_rel", 0, 4'b1001, 4'b0000, 2'd1);
      check_ptr("ign_ptr", 2'd2);
      cyc("ign_next3", 0, 4'b1001, 4'b1000, 2'd3);
      cyc("ign_rel3", 0, 4'b0000, 4'b0000, 2'd3);

      // Request withdrawn before the arbitration edge is never granted
      req = 4'b0100;
      #2;
      cyc("drop_before_edge", 0, 4'b0000, 4'b0000, 2'd3);

      // Asynchronous reset in the middle of a grant
      cyc("arst_g1", 0, 4'b0010, 4'b0010, 2'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_immediate", {gnt, sel, busy}, 7'd0);
      check_ptr("arst_ptr", 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc("arst_regrant", 0, 4'b0010, 4'b0010, 2'd1);
      cyc("arst_rel", 0, 4'b0000, 4'b0000, 2'd1);

      // HOLD_MAX=1: requesters 0 and 1 alternate with idle cycles between
      for (int k = 0; k < 3; k++) begin
         cyc("hm1_g0", 1, 4'b0011, 4'b0001, 2'd0);
         cyc("hm1_gap0", 1, 4'b0011, 4'b0000, 2'd0);
         cyc("hm1_g1", 1, 4'b0011, 4'b0010, 2'd1);
         cyc("hm1_gap1", 1, 4'b0011, 4'b0000, 2'd1);
      end
      req1 = 4'b0000;

      repeat (2) @(posedge clk);
      check("queue_empty", {6'd0, exp_q.size() == 0}, 7'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_rr_arbiter.md
ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, maximum consecutive cycles one requester keeps the grant (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  req[i]=1 means requester i asks for the shared 4->1 ALU operand path; level, held until served.
REQ-005 gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-006 sel  output  2  binary index of current/last granted requester, wired to the mux4 select of the shared path.
REQ-007 busy  output  1  high exactly when gnt is non-zero.

Function
REQ-008 Internal state: FSM {IDLE, GRANT}, 2-bit round-robin pointer ptr, hold counter cnt of width clog2(HOLD_MAX+1).
REQ-009 All outputs registered; no combinational path from req to any output.
REQ-010 IDLE, req==0: stay IDLE; gnt, busy stay 0; sel and ptr unchanged.
REQ-011 IDLE, req!=0: winner = first index i scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1; next edge: state GRANT, gnt=one-hot(i), sel=i, busy=1, cnt=1.
REQ-012 Grant latency: req sampled at edge N in IDLE -> gnt visible after edge N (one cycle).
REQ-013 GRANT, req[sel]==0 at an edge: release.
REQ-014 GRANT, req[sel]==1 and cnt==HOLD_MAX at an edge: release (forced preemption).
REQ-015 GRANT, req[sel]==1 and cnt<HOLD_MAX: stay GRANT, cnt=cnt+1, gnt/sel unchanged.
REQ-016 Release: next edge gnt=0, busy=0, state IDLE, ptr=(sel+1) mod 4, cnt=0; sel holds last granted index.
REQ-017 Every release is followed by at least one IDLE cycle; a new grant never follows a release on the same edge.
REQ-018 Grant duration = min(cycles req[sel] stays high after grant, HOLD_MAX) cycles; HOLD_MAX=1 gives single-cycle grants.
REQ-019 Requests from non-granted requesters during GRANT are ignored and do not alter ptr, cnt or gnt.
REQ-020 ptr wraps 3->0; a requester that just released has lowest priority in the next arbitration.
REQ-021 Requester that drops req in IDLE before arbitration edge is not granted; no grant is ever issued to an index with req=0 at the arbitration edge.
REQ-022 gnt is always zero or one-hot; busy==|gnt at all times.

Reset
REQ-023 rst_n low asynchronously forces: state IDLE, gnt=0, sel=0, busy=0, ptr=0, cnt=0, independent of clk.
REQ-024 Reset asserted mid-GRANT drops gnt/busy immediately (without waiting for clk edge).
REQ-025 After rst_n deasserts, first arbitration occurs on the first rising edge with req!=0; ptr=0 gives requester 0 highest priority.

Verification
REQ-026 Reset then req=4'b1111 held constant, HOLD_MAX=4 -> grants 0,1,2,3,0 each 4 cycles gnt-high, each separated by exactly 1 idle cycle; sel=0,1,2,3,0.
REQ-027 req=4'b0100 for 2 cycles after grant then 0 -> gnt=4'b0100 for 2 cycles, busy drops, sel stays 2, ptr=3.
REQ-028 ptr=3, req=4'b1001 -> gnt=4'b1000 first; after release ptr=0, next gnt=4'b0001 (wrap-around).
REQ-029 During grant to 1, raise req[0] and req[3] -> gnt stays 4'b0010 until release; next winner is 3 (scan from ptr=2: 2 idle, 3 requesting).
REQ-030 rst_n pulsed low mid-GRANT between clk edges -> gnt=0, busy=0, sel=0 immediately; with req=4'b0010 held, gnt=4'b0010 one edge after rst_n release.
REQ-031 HOLD_MAX=1, req=4'b0011 held -> alternating gnt 0001, 0000, 0010, 0000, 0001 ...; gnt never non-one-hot throughout (assertion on every cycle of all scenarios).
